// File: rtl/switch_monitor.sv
// switch_monitor: synchronises, debounces and decodes the six gate-driver feedback lines,
// tracks commutation and latches faults. Optional command cross-check: MISMATCH_CHECK_EN.
module switch_monitor #(
   parameter int DEB_CYCLES   = 3,
   parameter int COMM_TIMEOUT = 8,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Sfb,
   input  logic [5:0] Scmd,
   input  logic       clear_fault,
   output logic [1:0] ActiveLoad,
   output logic       load_valid,
   output logic       in_transition,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CONN  = 2'd1;
   localparam logic [1:0] ST_COMM  = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_SHORT    = 3'd1;
   localparam logic [2:0] FC_ILLEGAL  = 3'd2;
   localparam logic [2:0] FC_STUCK    = 3'd3;
   localparam logic [2:0] FC_MISMATCH = 3'd4;

   localparam logic [3:0]       DEB_LIM  = 4'(DEB_CYCLES);
   localparam logic [CNT_W-1:0] COMM_LIM = CNT_W'(COMM_TIMEOUT);

   function automatic logic [2:0] full_pairs(input logic [5:0] p);
      return {p[1] & p[0], p[3] & p[2], p[5] & p[4]};
   endfunction

   function automatic logic is_short(input logic [5:0] p);
      logic [2:0] f;
      f = full_pairs(p);
      return (f[0] & f[1]) | (f[0] & f[2]) | (f[1] & f[2]);
   endfunction

   function automatic logic is_illegal(input logic [5:0] p);
      return (p[5] | p[4]) & (p[3] | p[2]) & (p[1] | p[0]) & ~is_short(p);
   endfunction

   function automatic logic is_steady(input logic [5:0] p);
      return (p == 6'b000000) | (p == 6'b110000) | (p == 6'b001100) | (p == 6'b000011);
   endfunction

   function automatic logic [1:0] steady_code(input logic [5:0] p);
      logic [1:0] c;
      case (p)
         6'b110000: c = 2'b01;
         6'b001100: c = 2'b10;
         6'b000011: c = 2'b11;
         default:   c = 2'b00;
      endcase
      return c;
   endfunction

   logic [5:0]       s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, cand_q, cand_d;
   logic [3:0]       deb_cnt_q, deb_cnt_d, deb_run;
   logic             deb_new_q, deb_new_d;
   logic [1:0]       state_q, state_d, load_q, load_d;
   logic             valid_q, valid_d, trans_q, trans_d, fault_q, fault_d;
   logic [2:0]       code_q, code_d;
   logic [CNT_W-1:0] comm_cnt_q, comm_cnt_d, comm_inc;
   logic             stuck_hit, mismatch_hit;

   // The debounce watches the value being loaded into s2, so a pattern is accepted on the
   // edge that writes it into s2 for the DEB_CYCLES-th consecutive time.
   always_comb begin
      s1_d      = Sfb;
      s2_d      = s1_q;
      deb_d     = deb_q;
      cand_d    = cand_q;
      deb_cnt_d = deb_cnt_q;
      deb_new_d = 1'b0;
      deb_run   = 4'd0;
      if (s1_q == deb_q) begin
         deb_cnt_d = 4'd0;
      end else begin
         deb_run = (s1_q != cand_q) ? 4'd1 : deb_cnt_q + 4'd1;
         cand_d  = s1_q;
         if (deb_run == DEB_LIM) begin
            deb_d     = s1_q;
            deb_cnt_d = 4'd0;
            deb_new_d = 1'b1;
         end else begin
            deb_cnt_d = deb_run;
         end
      end
   end

   // The stuck timer restarts whenever the debounced pattern moves, so only a pattern that
   // sits unchanged for COMM_TIMEOUT cycles is reported as stuck.
   always_comb begin
      state_d    = state_q;
      load_d     = load_q;
      code_d     = code_q;
      comm_cnt_d = '0;
      comm_inc   = (comm_cnt_q == COMM_LIM) ? comm_cnt_q : comm_cnt_q + CNT_W'(1);
      stuck_hit  = (state_q == ST_COMM) && !is_steady(deb_q) && !deb_new_q &&
                   (comm_inc == COMM_LIM);
      if (state_q == ST_FAULT) begin
         if (clear_fault && (deb_q == 6'b000000) && !is_short(s2_q)) begin
            state_d = ST_IDLE;
            code_d  = FC_NONE;
            load_d  = 2'b00;
         end
      end else if (is_short(s2_q)) begin
         state_d = ST_FAULT;
         code_d  = FC_SHORT;
         load_d  = 2'b00;
      end else if (is_illegal(deb_q)) begin
         state_d = ST_FAULT;
         code_d  = FC_ILLEGAL;
         load_d  = 2'b00;
      end else if (stuck_hit) begin
         state_d = ST_FAULT;
         code_d  = FC_STUCK;
         load_d  = 2'b00;
      end else if (mismatch_hit) begin
         state_d = ST_FAULT;
         code_d  = FC_MISMATCH;
         load_d  = 2'b00;
      end else if (is_steady(deb_q)) begin
         state_d = (deb_q == 6'b000000) ? ST_IDLE : ST_CONN;
         load_d  = steady_code(deb_q);
      end else begin
         state_d = ST_COMM;
         if ((state_q == ST_COMM) && !deb_new_q) begin
            comm_cnt_d = comm_inc;
         end
      end
      valid_d = (state_d == ST_IDLE) || (state_d == ST_CONN);
      trans_d = (state_d == ST_COMM);
      fault_d = (state_d == ST_FAULT);
   end

`ifdef MISMATCH_CHECK_EN
   logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d, mm_inc;

   always_comb begin
      mm_inc       = (mm_cnt_q == COMM_LIM) ? mm_cnt_q : mm_cnt_q + CNT_W'(1);
      mismatch_hit = (deb_q != Scmd) && (mm_inc == COMM_LIM);
   end

   always_comb begin
      mm_cnt_d = '0;
      if ((state_q != ST_FAULT) && (state_d != ST_FAULT) && (deb_q != Scmd)) begin
         mm_cnt_d = mm_inc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mm_cnt_q <= '0;
      end else begin
         mm_cnt_q <= mm_cnt_d;
      end
   end
`else
   logic unused_scmd;
   assign unused_scmd  = ^Scmd;
   assign mismatch_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         deb_q      <= '0;
         cand_q     <= '0;
         deb_cnt_q  <= '0;
         deb_new_q  <= 1'b0;
         state_q    <= ST_IDLE;
         load_q     <= 2'b00;
         valid_q    <= 1'b0;
         trans_q    <= 1'b0;
         fault_q    <= 1'b0;
         code_q     <= FC_NONE;
         comm_cnt_q <= '0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         deb_q      <= deb_d;
         cand_q     <= cand_d;
         deb_cnt_q  <= deb_cnt_d;
         deb_new_q  <= deb_new_d;
         state_q    <= state_d;
         load_q     <= load_d;
         valid_q    <= valid_d;
         trans_q    <= trans_d;
         fault_q    <= fault_d;
         code_q     <= code_d;
         comm_cnt_q <= comm_cnt_d;
      end
   end

   assign ActiveLoad    = load_q;
   assign load_valid    = valid_q;
   assign in_transition = trans_q;
   assign fault         = fault_q;
   assign fault_code    = code_q;

endmodule
